// File: rtl/uart_baud_ctrl.sv
// Baud generator controller: owns the prescaler count and the live divisor,
// applying new divisors only on a 1x tick boundary and gating the generator with en.
module uart_baud_ctrl #(
   parameter int unsigned           DIV_W       = 16,
   parameter logic [DIV_W-1:0]      DEFAULT_DIV = 16'd27,
   parameter logic [DIV_W-1:0]      MIN_DIV     = 16'd2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_done,
   output logic             cfg_err,
   input  logic             rst_c,
   input  logic             tick_1x,
   output logic [DIV_W-1:0] count,
   output logic [DIV_W-1:0] baud_div,
   output logic             gen_rst_n,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [DIV_W-1:0] count_q, count_d;
   logic [DIV_W-1:0] baud_div_q, baud_div_d;
   logic [DIV_W-1:0] pend_div_q, pend_div_d;
   logic             cfg_done_q, cfg_done_d;
   logic             cfg_err_q, cfg_err_d;

   logic             xfer;
   logic             div_legal;
   logic [DIV_W-1:0] div_m1;
   logic [DIV_W-1:0] count_run;

   assign cfg_ready = (state_q != PEND);
   assign busy      = (state_q == PEND);
   assign gen_rst_n = (state_q != IDLE);
   assign count     = count_q;
   assign baud_div  = baud_div_q;
   assign cfg_done  = cfg_done_q;
   assign cfg_err   = cfg_err_q;

   assign xfer      = cfg_valid & cfg_ready;
   assign div_legal = (cfg_div >= MIN_DIV);
   // baud_div never drops below MIN_DIV, so this cannot underflow.
   assign div_m1    = baud_div_q - ONE;
   assign count_run = (rst_c || (count_q >= div_m1)) ? '0 : (count_q + ONE);

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      baud_div_d = baud_div_q;
      pend_div_d = pend_div_q;
      cfg_done_d = 1'b0;
      cfg_err_d  = xfer & ~div_legal;

      case (state_q)
         IDLE: begin
            count_d = '0;
            if (xfer && div_legal) begin
               baud_div_d = cfg_div;
               cfg_done_d = 1'b1;
            end
            if (en) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!en) begin
               state_d = IDLE;
               count_d = '0;
               if (xfer && div_legal) begin
                  baud_div_d = cfg_div;
                  cfg_done_d = 1'b1;
               end
            end else begin
               count_d = count_run;
               if (xfer && div_legal) begin
                  pend_div_d = cfg_div;
                  state_d    = PEND;
               end
            end
         end
         PEND: begin
            // Disable flushes the pending divisor immediately rather than losing it.
            if (!en) begin
               baud_div_d = pend_div_q;
               cfg_done_d = 1'b1;
               count_d    = '0;
               state_d    = IDLE;
            end else if (tick_1x) begin
               baud_div_d = pend_div_q;
               cfg_done_d = 1'b1;
               count_d    = '0;
               state_d    = RUN;
            end else begin
               count_d = count_run;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         count_q    <= '0;
         baud_div_q <= DEFAULT_DIV;
         pend_div_q <= DEFAULT_DIV;
         cfg_done_q <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         baud_div_q <= baud_div_d;
         pend_div_q <= pend_div_d;
         cfg_done_q <= cfg_done_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

endmodule
